// File: rtl/kseq_chain_engine.sv
// Multi-channel chained add-step sequencer: seed load, LOOP_CNT chain
// iterations, then a one-cycle done pulse. Abortable at any busy state.
module kseq_chain_engine #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int LOOP_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WIDTH-1:0]          seed,
    input  logic [WIDTH-1:0]          step,
    output logic [CHANNELS*WIDTH-1:0] ch_out,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          run_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int ITER_W = (LOOP_CNT > 1) ? $clog2(LOOP_CNT) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(LOOP_CNT - 1);

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  ch_q [CHANNELS];
    logic [WIDTH-1:0]  ch_d [CHANNELS];
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_INIT;
            end
            S_INIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d[0] = seed;
                    for (int i = 1; i < CHANNELS; i++) ch_d[i] = '0;
                    iter_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // every channel takes its predecessor's pre-edge value
                    ch_d[0] = ch_q[0] + step;
                    for (int i = 1; i < CHANNELS; i++) ch_d[i] = ch_q[i-1] + step;
                    iter_d = iter_q + 1'b1;
                    if (iter_q == ITER_LAST) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!abort) cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) ch_q[i] <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < CHANNELS; i++) ch_q[i] <= ch_d[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign ch_out[g*WIDTH +: WIDTH] = ch_q[g];
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign run_count = cnt_q;

endmodule
